// File: rtl/mvm_pkg.sv
// Shared types and default sizes for the MVM sequencing controller.
// Contents: FSM state enum, default width constants, result record (row, data).
package mvm_pkg;

  localparam int unsigned DEF_IWIDTH     = 8;
  localparam int unsigned DEF_OWIDTH     = 32;
  localparam int unsigned DEF_MAX_ROWS   = 64;
  localparam int unsigned DEF_MAX_CHUNKS = 16;
  localparam int unsigned DEF_DOT_LAT    = 5;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_ROW_W      = $clog2(DEF_MAX_ROWS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Result record at the default widths; the top re-declares the same layout
  // at its own parameterised widths.
  typedef struct packed {
    logic [DEF_ROW_W-1:0]  row;
    logic [DEF_OWIDTH-1:0] data;
  } res_t;

endpackage

// File: rtl/mvm_res_fifo.sv
// Result queue: synchronous FIFO of result records with a show-ahead head.
// Ports: i_clk, i_rst (sync, active high), i_push/i_wdata, i_pop,
//        o_rdata (current head), o_empty, o_full.
module mvm_res_fifo
  import mvm_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter type         T     = res_t
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  T     i_wdata,
  input  logic i_pop,
  output T     o_rdata,
  output logic o_empty,
  output logic o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  T           r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (i_pop && !o_empty) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/mvm_sched.sv
// Sequencing controller for the 8-lane dot-product pipeline (y = M*x).
// Issues operand reads, delays mem_ren into dot_ivalid, accumulates chunk
// results into row sums and queues finished rows on a valid/ready port.
// Ports: i_clk, i_rst (sync, active high), i_start/i_num_rows/i_num_chunks
//        (job request), o_busy, o_done, o_mem_ren/o_mat_raddr/o_vec_raddr
//        (memory reads), o_dot_ivalid, i_dot_result/i_dot_ovalid,
//        o_out_data/o_out_row/o_out_valid/i_out_ready (result queue).
// Build option: MVM_SCHED_SAT_EN makes the row accumulator saturate (sticky)
// instead of wrapping.
module mvm_sched
  import mvm_pkg::*;
#(
  parameter int unsigned IWIDTH     = DEF_IWIDTH,
  parameter int unsigned OWIDTH     = DEF_OWIDTH,
  parameter int unsigned MAX_ROWS   = DEF_MAX_ROWS,
  parameter int unsigned MAX_CHUNKS = DEF_MAX_CHUNKS,
  parameter int unsigned DOT_LAT    = DEF_DOT_LAT,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned RW   = $clog2(MAX_ROWS + 1),
  localparam int unsigned CW   = $clog2(MAX_CHUNKS + 1),
  localparam int unsigned AW   = $clog2(MAX_ROWS * MAX_CHUNKS),
  localparam int unsigned VW   = $clog2(MAX_CHUNKS),
  localparam int unsigned ROWW = $clog2(MAX_ROWS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [RW-1:0]     i_num_rows,
  input  logic [CW-1:0]     i_num_chunks,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_ren,
  output logic [AW-1:0]     o_mat_raddr,
  output logic [VW-1:0]     o_vec_raddr,
  output logic              o_dot_ivalid,
  input  logic [OWIDTH-1:0] i_dot_result,
  input  logic              i_dot_ovalid,
  output logic [OWIDTH-1:0] o_out_data,
  output logic [ROWW-1:0]   o_out_row,
  output logic              o_out_valid,
  input  logic              i_out_ready
);

  localparam int unsigned CRW = $clog2(FIFO_DEPTH + 1);

  // Reject unusable configurations at elaboration.
  if (IWIDTH == 0 || DOT_LAT == 0 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("mvm_sched: invalid parameter set");
  end

  typedef struct packed {
    logic [ROWW-1:0]   row;
    logic [OWIDTH-1:0] data;
  } res_rec_t;

  state_t            r_state, w_next;
  logic [RW-1:0]     r_nrows, r_irow, r_rrow;
  logic [CW-1:0]     r_nchunks, r_ichunk, r_rchunk;
  logic [AW-1:0]     r_mat_next;
  logic [CRW-1:0]    r_credits;
  logic [OWIDTH-1:0] r_acc, w_acc_next;
  logic              r_push, r_busy, r_done, r_mem_ren, r_dot_ivalid;
  logic [AW-1:0]     r_mat_raddr;
  logic [VW-1:0]     r_vec_raddr;
  res_rec_t          r_push_rec, w_head;
  logic              w_empty, w_full, w_pop;
  logic              w_issue, w_latch, w_consume, w_last_chunk, w_last_row;
  logic [RW-1:0]     w_cur_row, w_nrows;
  logic [CW-1:0]     w_cur_chunk, w_nch;
  logic [AW-1:0]     w_cur_mat;

  // In IDLE the first chunk issues straight from the request inputs.
  always_comb begin
    w_cur_row   = r_irow;
    w_cur_chunk = r_ichunk;
    w_cur_mat   = r_mat_next;
    w_nrows     = r_nrows;
    w_nch       = r_nchunks;
    if (r_state == S_IDLE) begin
      w_cur_row   = '0;
      w_cur_chunk = '0;
      w_cur_mat   = '0;
      w_nrows     = i_num_rows;
      w_nch       = i_num_chunks;
    end
    w_last_chunk = (w_cur_chunk == w_nch - CW'(1));
    w_last_row   = (w_cur_row == w_nrows - RW'(1));
  end

  // Next-state and issue decision.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_num_rows == '0 || i_num_chunks == '0) begin
            w_next = S_DONE;
          end else begin
            w_latch = 1'b1;
            w_issue = 1'b1;
            w_next  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (r_irow == r_nrows) begin
          w_next = S_DRAIN;
        end else if (r_ichunk != '0 || r_credits != '0) begin
          w_issue = 1'b1;
          if (w_last_chunk && w_last_row) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_rrow == r_nrows && !r_push && w_empty) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_consume = w_issue && (w_cur_chunk == '0);
  assign w_pop     = !w_empty && i_out_ready;

`ifdef MVM_SCHED_SAT_EN
  logic             r_sat_pos, r_sat_neg, w_sat_pos, w_sat_neg;
  logic [OWIDTH:0]  w_sum;

  // Saturating add; once a row clamps it stays at that rail until row end.
  always_comb begin
    w_sum      = {r_acc[OWIDTH-1], r_acc} + {i_dot_result[OWIDTH-1], i_dot_result};
    w_acc_next = w_sum[OWIDTH-1:0];
    w_sat_pos  = r_sat_pos;
    w_sat_neg  = r_sat_neg;
    if (r_rchunk == '0) begin
      w_acc_next = i_dot_result;
      w_sat_pos  = 1'b0;
      w_sat_neg  = 1'b0;
    end else if (r_sat_pos || (!w_sum[OWIDTH] && w_sum[OWIDTH-1])) begin
      w_acc_next = {1'b0, {(OWIDTH-1){1'b1}}};
      w_sat_pos  = 1'b1;
    end else if (r_sat_neg || (w_sum[OWIDTH] && !w_sum[OWIDTH-1])) begin
      w_acc_next = {1'b1, {(OWIDTH-1){1'b0}}};
      w_sat_neg  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sat_pos <= 1'b0;
      r_sat_neg <= 1'b0;
    end else if (i_dot_ovalid && r_state != S_IDLE) begin
      r_sat_pos <= w_sat_pos;
      r_sat_neg <= w_sat_neg;
    end
  end
`else
  // Wrapping add modulo 2^OWIDTH.
  always_comb begin
    w_acc_next = (r_rchunk == '0) ? i_dot_result : r_acc + i_dot_result;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_dot_ivalid <= 1'b0;
      r_mat_raddr  <= '0;
      r_vec_raddr  <= '0;
      r_nrows      <= '0;
      r_nchunks    <= '0;
      r_irow       <= '0;
      r_ichunk     <= '0;
      r_mat_next   <= '0;
      r_credits    <= CRW'(FIFO_DEPTH);
      r_rrow       <= '0;
      r_rchunk     <= '0;
      r_acc        <= '0;
      r_push       <= 1'b0;
      r_push_rec   <= '0;
    end else begin
      r_state      <= w_next;
      r_busy       <= (w_next != S_IDLE);
      r_done       <= (w_next == S_DONE);
      r_mem_ren    <= w_issue;
      r_dot_ivalid <= r_mem_ren;
      r_push       <= 1'b0;

      if (w_latch) begin
        r_nrows   <= i_num_rows;
        r_nchunks <= i_num_chunks;
      end

      // Issue counters; the matrix address is a running counter.
      if (w_issue) begin
        r_mat_raddr <= w_cur_mat;
        r_vec_raddr <= VW'(w_cur_chunk);
        r_mat_next  <= w_cur_mat + AW'(1);
        if (w_last_chunk) begin
          r_ichunk <= '0;
          r_irow   <= w_cur_row + RW'(1);
        end else begin
          r_ichunk <= w_cur_chunk + CW'(1);
          r_irow   <= w_cur_row;
        end
      end

      if (w_consume && !w_pop)      r_credits <= r_credits - CRW'(1);
      else if (!w_consume && w_pop) r_credits <= r_credits + CRW'(1);

      // Receive side: results arrive in issue order, untagged.
      if (w_latch) begin
        r_rrow   <= '0;
        r_rchunk <= '0;
      end else if (i_dot_ovalid && r_state != S_IDLE) begin
        r_acc <= w_acc_next;
        if (r_rchunk == r_nchunks - CW'(1)) begin
          r_push          <= 1'b1;
          r_push_rec.row  <= ROWW'(r_rrow);
          r_push_rec.data <= w_acc_next;
          r_rchunk        <= '0;
          r_rrow          <= r_rrow + RW'(1);
        end else begin
          r_rchunk <= r_rchunk + CW'(1);
        end
      end
    end
  end

  mvm_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (res_rec_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_push && !w_full),
    .i_wdata (r_push_rec),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_mem_ren    = r_mem_ren;
  assign o_mat_raddr  = r_mat_raddr;
  assign o_vec_raddr  = r_vec_raddr;
  assign o_dot_ivalid = r_dot_ivalid;
  assign o_out_data   = w_head.data;
  assign o_out_row    = w_head.row;
  assign o_out_valid  = !w_empty;

endmodule

// File: tb/tb_mvm_sched.sv
// Bench for mvm_sched: operand memories plus a dot-product model with real
// latency, scoreboard of expected row results, and directed job scenarios.
module tb_mvm_sched;

  localparam int DOT_LAT = 5;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [6:0]  num_rows;
  logic [4:0]  num_chunks;
  logic        busy, done, mem_ren, dot_ivalid, dot_ovalid, out_valid;
  logic [9:0]  mat_raddr;
  logic [3:0]  vec_raddr;
  logic [31:0] dot_result, out_data;
  logic [5:0]  out_row;

  always #5 clk = ~clk;

  mvm_sched dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_num_rows(num_rows), .i_num_chunks(num_chunks),
    .o_busy(busy), .o_done(done), .o_mem_ren(mem_ren),
    .o_mat_raddr(mat_raddr), .o_vec_raddr(vec_raddr),
    .o_dot_ivalid(dot_ivalid), .i_dot_result(dot_result),
    .i_dot_ovalid(dot_ovalid), .o_out_data(out_data),
    .o_out_row(out_row), .o_out_valid(out_valid), .i_out_ready(out_ready)
  );

  // Operand memories and dot-product model (1-cycle read, DOT_LAT pipeline).
  logic signed [7:0] mat_mem [1024][8];
  logic signed [7:0] vec_mem [16][8];
  logic [31:0]       inj_val [1024];
  bit                inj_en = 1'b0;
  bit [9:0]          rd_mat;
  bit [3:0]          rd_vec;
  bit                pv [DOT_LAT];
  bit [31:0]         pd [DOT_LAT];

  function automatic logic [31:0] dot8(input bit [9:0] a, input bit [3:0] v);
    int s = 0;
    for (int k = 0; k < 8; k++) s += int'(mat_mem[a][k]) * int'(vec_mem[v][k]);
    return 32'(s);
  endfunction

  always @(posedge clk) begin
    if (mem_ren) begin
      rd_mat <= mat_raddr;
      rd_vec <= vec_raddr;
    end
    pv[0] <= dot_ivalid;
    pd[0] <= inj_en ? inj_val[rd_mat] : dot8(rd_mat, rd_vec);
    for (int i = 1; i < DOT_LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign dot_ovalid = pv[DOT_LAT-1];
  assign dot_result = pd[DOT_LAT-1];

  // Checking infrastructure.
  typedef struct packed { logic [5:0] row; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, done_cnt = 0, valid_cnt = 0, job_cyc = 0, first_valid_cyc = 0;
  bit   seen_valid = 1'b0;
  logic [9:0] mat_log[$];
  logic [3:0] vec_log[$];
  int         cyc_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every accepted output.
  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid && out_ready) begin
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_row", 64'(out_row), 64'(e.row));
        check("out_data", 64'(out_data), 64'(e.data));
      end
    end
    if (out_valid && !seen_valid) begin
      seen_valid      = 1'b1;
      first_valid_cyc = cyc;
    end
    if (out_valid) valid_cnt++;
    if (done) done_cnt++;
    if (mem_ren) begin
      mat_log.push_back(mat_raddr);
      vec_log.push_back(vec_raddr);
      cyc_log.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job(input int rows, input int chunks);
    seen_valid = 1'b0;
    mat_log.delete();
    vec_log.delete();
    cyc_log.delete();
    start      = 1'b1;
    num_rows   = 7'(rows);
    num_chunks = 5'(chunks);
    job_cyc    = cyc;
    tick(1);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen, or after the budget expires.
  task automatic wait_done(input string name, input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_mem_ren"}, 64'(mem_ren), 64'd0);
    check({name, "_mat_raddr"}, 64'(mat_raddr), 64'd0);
    check({name, "_vec_raddr"}, 64'(vec_raddr), 64'd0);
    check({name, "_dot_ivalid"}, 64'(dot_ivalid), 64'd0);
    check({name, "_out_valid"}, 64'(out_valid), 64'd0);
    check({name, "_out_data"}, 64'(out_data), 64'd0);
    check({name, "_out_row"}, 64'(out_row), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, v0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; num_rows = '0; num_chunks = '0;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // 2 rows x 1 chunk, M=1, x=2 -> 16, 16; first out_valid 9 cycles after start.
    for (int r = 0; r < 2; r++) for (int k = 0; k < 8; k++) mat_mem[r][k] = 8'sd1;
    for (int k = 0; k < 8; k++) vec_mem[0][k] = 8'sd2;
    sb.push_back('{row: 6'd0, data: 32'd16});
    sb.push_back('{row: 6'd1, data: 32'd16});
    d0 = done_cnt;
    start_job(2, 1);
    wait_done("t1", 100);
    tick(3);
    check("t1_latency", 64'(first_valid_cyc - job_cyc), 64'd9);
    check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);
    check("t1_busy_low", 64'(busy), 64'd0);

    // 3 rows x 3 chunks, M[r]=r+1, x=1 -> 24, 48, 72; contiguous addresses.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < 8; k++) mat_mem[r*3+c][k] = 8'(r + 1);
    for (int c = 0; c < 3; c++) for (int k = 0; k < 8; k++) vec_mem[c][k] = 8'sd1;
    for (int r = 0; r < 3; r++) sb.push_back('{row: 6'(r), data: 32'(24 * (r + 1))});
    d0 = done_cnt;
    start_job(3, 3);
    tick(3);
    start = 1'b1; num_rows = 7'd5; num_chunks = 5'd2;   // must be ignored while busy
    tick(1);
    start = 1'b0;
    wait_done("t2", 100);
    tick(2);
    check("t2_latency", 64'(first_valid_cyc - job_cyc), 64'd11);
    check("t2_ren_count", 64'(mat_log.size()), 64'd9);
    for (int i = 0; i < mat_log.size() && i < 9; i++) begin
      check($sformatf("t2_mat_raddr_%0d", i), 64'(mat_log[i]), 64'(i));
      check($sformatf("t2_vec_raddr_%0d", i), 64'(vec_log[i]), 64'(i % 3));
      check($sformatf("t2_no_gap_%0d", i), 64'(cyc_log[i] - cyc_log[0]), 64'(i));
    end
    check("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 6 rows x 1 chunk with consumer stalled: only 4 credits' worth issue.
    for (int r = 0; r < 6; r++) for (int k = 0; k < 8; k++) mat_mem[r][k] = 8'(r + 1);
    for (int k = 0; k < 8; k++) vec_mem[0][k] = 8'sd1;
    for (int r = 0; r < 6; r++) sb.push_back('{row: 6'(r), data: 32'(8 * (r + 1))});
    out_ready = 1'b0;
    start_job(6, 1);
    tick(30);
    check("t3_stalled_reads", 64'(mat_log.size()), 64'd4);
    check("t3_mem_ren_idle", 64'(mem_ren), 64'd0);
    check("t3_queue_full_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_done("t3", 200);
    tick(2);
    check("t3_total_reads", 64'(mat_log.size()), 64'd6);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Empty jobs: straight to DONE, no reads.
    d0 = done_cnt;
    start_job(0, 3);
    wait_done("t4a", 20);
    check("t4a_busy_in_done", 64'(busy), 64'd1);
    tick(2);
    check("t4a_busy_low", 64'(busy), 64'd0);
    check("t4a_no_reads", 64'(mat_log.size()), 64'd0);
    start_job(2, 0);
    wait_done("t4b", 20);
    tick(2);
    check("t4b_no_reads", 64'(mat_log.size()), 64'd0);
    check("t4_done_pulses", 64'(done_cnt - d0), 64'd2);

    // Overflowing rows with injected chunk results: sticky clamp vs wrap.
    inj_val[0] = 32'h7000_0000; inj_val[1] = 32'h7000_0000;
    inj_val[2] = 32'hF000_0000; inj_val[3] = 32'h0000_0000;
    inj_val[4] = 32'h8000_0000; inj_val[5] = 32'hFFFF_FFFF;
    inj_val[6] = 32'h2000_0000; inj_val[7] = 32'h0000_0001;
`ifdef MVM_SCHED_SAT_EN
    sb.push_back('{row: 6'd0, data: 32'h7FFF_FFFF});
    sb.push_back('{row: 6'd1, data: 32'h8000_0000});
`else
    sb.push_back('{row: 6'd0, data: 32'hD000_0000});
    sb.push_back('{row: 6'd1, data: 32'hA000_0000});
`endif
    inj_en = 1'b1;
    start_job(2, 4);
    wait_done("t5", 100);
    tick(2);
    inj_en = 1'b0;
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-RUN with results in flight; late results must not push.
    for (int a = 0; a < 8; a++) for (int k = 0; k < 8; k++) mat_mem[a][k] = 8'sd1;
    for (int c = 0; c < 4; c++) for (int k = 0; k < 8; k++) vec_mem[c][k] = 8'sd1;
    start_job(2, 4);
    tick(3);
    rst = 1'b1;
    tick(1);
    check_all_zero("midreset");
    rst = 1'b0;
    v0 = valid_cnt;
    tick(15);
    check("midreset_no_push", 64'(valid_cnt - v0), 64'd0);
    check("midreset_idle", 64'(busy), 64'd0);
    for (int k = 0; k < 8; k++) begin
      mat_mem[0][k] = 8'sd3;
      vec_mem[0][k] = 8'sd2;
    end
    sb.push_back('{row: 6'd0, data: 32'd48});
    start_job(1, 1);
    wait_done("t6", 100);
    tick(3);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
